// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: plays a writable byte buffer out to the UART transmitter
// over an isTX level / tx_done pulse handshake. It supports a runtime message
// length, an inter-byte gap, continuous repeat and abort.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; isTX low, busy low
// S_LOAD | copying buf[byte_idx] into the tx_data register
// S_SEND | isTX high, waiting for tx_done from the transmitter
// S_GAP  | isTX low for G cycles before the next byte is loaded
module uart_msg_sequencer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              start,
  input  logic              repeat_mode,
  input  logic              abort,
  input  logic              tx_done,
  output logic              isTX,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              msg_done,
  output logic [ADDR_W-1:0] byte_idx,
  output logic [7:0]        pass_cnt
);

  // A zero gap would let isTX stay high between bytes, so at least one GAP
  // cycle is always inserted; with LOAD that gives >=2 low cycles.
  localparam int G     = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W = (G > 1) ? $clog2(G) : 1;

  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(G - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     w_len_nxt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [GAP_W-1:0]    w_gap_cnt_nxt;
  logic                r_istx;
  logic                w_istx_nxt;
  logic [DATA_W-1:0]   r_tx_data;
  logic [DATA_W-1:0]   w_tx_data_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_msg_done;
  logic                w_msg_done_nxt;
  logic [ADDR_W-1:0]   r_byte_idx;
  logic [ADDR_W-1:0]   w_byte_idx_nxt;
  logic [7:0]          r_pass_cnt;
  logic [7:0]          w_pass_cnt_nxt;
  logic                w_last;

  // Message buffer: written in any state; a same-cycle LOAD sees the old byte.
  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign w_last = ({1'b0, r_byte_idx} == (r_len - LEN_ONE));

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_byte_idx_nxt = r_byte_idx;
    w_pass_cnt_nxt = r_pass_cnt;
    w_msg_done_nxt = 1'b0;

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (msg_len != '0)) begin
            w_len_nxt      = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
            w_byte_idx_nxt = '0;
            w_pass_cnt_nxt = '0;
            w_state_nxt    = S_LOAD;
          end
        end
        S_LOAD: begin
          w_tx_data_nxt = r_mem[r_byte_idx];
          w_state_nxt   = S_SEND;
        end
        S_SEND: begin
          if (tx_done) begin
            if (!w_last) begin
              w_byte_idx_nxt = r_byte_idx + IDX_ONE;
              w_gap_cnt_nxt  = GAP_LOAD;
              w_state_nxt    = S_GAP;
            end else if (repeat_mode) begin
              w_pass_cnt_nxt = r_pass_cnt + 8'd1;
              w_byte_idx_nxt = '0;
              w_gap_cnt_nxt  = GAP_LOAD;
              w_state_nxt    = S_GAP;
            end else begin
              w_pass_cnt_nxt = r_pass_cnt + 8'd1;
              w_msg_done_nxt = 1'b1;
              w_state_nxt    = S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Outputs are registered versions of the state being entered.
    w_istx_nxt = (w_state_nxt == S_SEND);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_gap_cnt  <= '0;
      r_istx     <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_msg_done <= 1'b0;
      r_byte_idx <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_istx     <= w_istx_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= w_busy_nxt;
      r_msg_done <= w_msg_done_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_pass_cnt <= w_pass_cnt_nxt;
    end
  end

  assign isTX     = r_istx;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign msg_done = r_msg_done;
  assign byte_idx = r_byte_idx;
  assign pass_cnt = r_pass_cnt;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Bench for uart_msg_sequencer: one instance with the default gap and one with
// GAP_CYCLES=3, both sharing the write bus, checked against a buffer model and
// the handshake timing rules.
module tb_uart_msg_sequencer;

  localparam int G0 = 1;   // effective gap of dut0 (GAP_CYCLES=0)
  localparam int G1 = 3;   // effective gap of dut1

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] msg_len = '0;
  logic       start = 1'b0;
  logic       repeat_mode = 1'b0;
  logic       abort = 1'b0;
  logic       tx_done = 1'b0;
  logic       isTX, busy, msg_done;
  logic [7:0] tx_data, pass_cnt;
  logic [3:0] byte_idx;

  logic       start1 = 1'b0;
  logic       repeat1 = 1'b0;
  logic       abort1 = 1'b0;
  logic       tx_done1 = 1'b0;
  logic       isTX1, busy1, msg_done1;
  logic [7:0] tx_data1, pass_cnt1;
  logic [3:0] byte_idx1;

  logic [7:0] mem_model [16];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_msg_done = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (msg_done === 1'b1) n_msg_done <= n_msg_done + 1;

  uart_msg_sequencer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .GAP_CYCLES(0)) dut0 (
    .CLK100MHZ(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .msg_len(msg_len), .start(start),
    .repeat_mode(repeat_mode), .abort(abort), .tx_done(tx_done),
    .isTX(isTX), .tx_data(tx_data), .busy(busy), .msg_done(msg_done),
    .byte_idx(byte_idx), .pass_cnt(pass_cnt)
  );

  uart_msg_sequencer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .GAP_CYCLES(3)) dut1 (
    .CLK100MHZ(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .msg_len(msg_len), .start(start1),
    .repeat_mode(repeat1), .abort(abort1), .tx_done(tx_done1),
    .isTX(isTX1), .tx_data(tx_data1), .busy(busy1), .msg_done(msg_done1),
    .byte_idx(byte_idx1), .pass_cnt(pass_cnt1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_buf(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mem_model[a] = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic wait_istx(output int n);
    n = 0;
    while (isTX !== 1'b1 && n < 40) begin tick; n++; end
  endtask

  task automatic wait_istx1(output int n);
    n = 0;
    while (isTX1 !== 1'b1 && n < 40) begin tick; n++; end
  endtask

  // poke: 1 = start request while busy, 2 = overwrite buf[3] with EE
  task automatic serve_byte(input string tag, input int exp_wait, input logic [7:0] exp_byte,
                            input int exp_idx, input int lat, input int poke);
    int n;
    wait_istx(n);
    chk({tag, ".wait"}, n, exp_wait);
    chk({tag, ".data"}, tx_data, exp_byte);
    chk({tag, ".idx"}, byte_idx, exp_idx);
    for (int k = 0; k < lat; k++) begin
      if (k == 0 && poke == 1) begin start = 1'b1; msg_len = 5'd1; end
      if (k == 0 && poke == 2) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hEE; mem_model[3] = 8'hEE;
      end
      tick;
      start = 1'b0; wr_en = 1'b0;
    end
    chk({tag, ".hold"}, isTX, 1);
    chk({tag, ".stable"}, tx_data, exp_byte);
    tx_done = 1'b1; tick; tx_done = 1'b0;
    chk({tag, ".drop"}, isTX, 0);
  endtask

  task automatic run_msg(input string tag, input int len, input int lat_fix,
                         input int poke_at, input int poke);
    int nb;
    int done0;
    nb = (len > 16) ? 16 : len;
    done0 = n_msg_done;
    msg_len = 5'(len); start = 1'b1; tick; start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".pass0"}, pass_cnt, 0);
    for (int i = 0; i < nb; i++)
      serve_byte(tag, (i == 0) ? 1 : G0 + 1, mem_model[i], i,
                 (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 8)),
                 (i == poke_at) ? poke : 0);
    chk({tag, ".done"}, msg_done, 1);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".pass"}, pass_cnt, 1);
    chk({tag, ".lastidx"}, byte_idx, nb - 1);
    tick;
    chk({tag, ".pulse"}, msg_done, 0);
    chk({tag, ".ndone"}, n_msg_done - done0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int done0;

    // reset values
    reset = 1'b1; tick; tick; reset = 1'b0;
    chk("rst.isTX", isTX, 0);
    chk("rst.tx_data", tx_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.msg_done", msg_done, 0);
    chk("rst.byte_idx", byte_idx, 0);
    chk("rst.pass_cnt", pass_cnt, 0);
    chk("rst.busy1", busy1, 0);

    for (int i = 0; i < 16; i++) write_buf(4'(i), 8'($urandom));

    // basic four-byte message, fixed latency, start request while busy
    write_buf(4'd0, 8'hA1); write_buf(4'd1, 8'hB2);
    write_buf(4'd2, 8'hC3); write_buf(4'd3, 8'hD4);
    run_msg("basic", 4, 10, 1, 1);

    // randomized contents and lengths
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) write_buf(4'(i), 8'($urandom));
      run_msg("rand", int'($urandom_range(1, 16)), 0, -1, 0);
    end

    // over-long length is clipped to the buffer depth
    run_msg("len31", 31, 0, -1, 0);

    // zero length start is ignored
    done0 = n_msg_done;
    msg_len = 5'd0; start = 1'b1; tick; start = 1'b0;
    chk("len0.busy", busy, 0);
    tick; tick;
    chk("len0.busy2", busy, 0);
    chk("len0.isTX", isTX, 0);
    chk("len0.ndone", n_msg_done - done0, 0);

    // stray tx_done in IDLE
    tx_done = 1'b1; tick; tx_done = 1'b0;
    chk("stray.busy", busy, 0);
    chk("stray.isTX", isTX, 0);
    chk("stray.pass", pass_cnt, 1);

    // repeat mode, cleared during the last byte of pass 3
    write_buf(4'd0, 8'h55); write_buf(4'd1, 8'hAA);
    done0 = n_msg_done;
    repeat_mode = 1'b1; msg_len = 5'd2; start = 1'b1; tick; start = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      for (int b = 0; b < 2; b++) begin
        if (p == 3 && b == 1) repeat_mode = 1'b0;
        serve_byte("rep", (p == 1 && b == 0) ? 1 : G0 + 1, mem_model[b], b,
                   int'($urandom_range(1, 6)), 0);
      end
      if (p < 3) begin
        chk("rep.pass", pass_cnt, p);
        chk("rep.wrap", byte_idx, 0);
        chk("rep.nodone", msg_done, 0);
        chk("rep.busy", busy, 1);
      end else begin
        chk("rep.done", msg_done, 1);
        chk("rep.pass3", pass_cnt, 3);
        chk("rep.idle", busy, 0);
      end
    end
    tick;
    chk("rep.ndone", n_msg_done - done0, 1);

    // abort together with tx_done on byte 2, then restart
    for (int i = 0; i < 4; i++) write_buf(4'(i), 8'($urandom));
    done0 = n_msg_done;
    msg_len = 5'd4; start = 1'b1; tick; start = 1'b0;
    serve_byte("abt", 1, mem_model[0], 0, int'($urandom_range(1, 6)), 0);
    wait_istx(n);
    chk("abt.wait", n, G0 + 1);
    chk("abt.data", tx_data, mem_model[1]);
    abort = 1'b1; tx_done = 1'b1; tick; abort = 1'b0; tx_done = 1'b0;
    chk("abt.isTX", isTX, 0);
    chk("abt.busy", busy, 0);
    chk("abt.nodone", msg_done, 0);
    chk("abt.idx", byte_idx, 1);
    chk("abt.pass", pass_cnt, 0);
    tick; tick; tick;
    chk("abt.busy2", busy, 0);
    chk("abt.ndone", n_msg_done - done0, 0);
    run_msg("restart", 4, 0, -1, 0);

    // buffer write during byte 1 affects byte 3 of the same pass
    write_buf(4'd3, 8'h33);
    run_msg("wr", 5, 0, 1, 2);

    // reset in the middle of a repeating pass
    repeat_mode = 1'b1; msg_len = 5'd2; start = 1'b1; tick; start = 1'b0;
    serve_byte("mid", 1, mem_model[0], 0, 3, 0);
    serve_byte("mid", G0 + 1, mem_model[1], 1, 3, 0);
    serve_byte("mid", G0 + 1, mem_model[0], 0, 3, 0);
    wait_istx(n);
    chk("mid.pass", pass_cnt, 1);
    reset = 1'b1; tick; reset = 1'b0; repeat_mode = 1'b0;
    chk("mid.isTX", isTX, 0);
    chk("mid.tx_data", tx_data, 0);
    chk("mid.busy", busy, 0);
    chk("mid.msg_done", msg_done, 0);
    chk("mid.byte_idx", byte_idx, 0);
    chk("mid.pass_cnt", pass_cnt, 0);

    // gap timing on the GAP_CYCLES=3 instance
    msg_len = 5'd3; start1 = 1'b1; tick; start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_istx1(n);
      chk("gap.wait", n, (i == 0) ? 1 : G1 + 1);
      chk("gap.data", tx_data1, mem_model[i]);
      repeat (int'($urandom_range(1, 6))) tick;
      tx_done1 = 1'b1; tick; tx_done1 = 1'b0;
      chk("gap.drop", isTX1, 0);
    end
    chk("gap.done", msg_done1, 1);
    chk("gap.idle", busy1, 0);
    chk("gap.pass", pass_cnt1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
